// File: rtl/matmul_scheduler.sv
// Sequencer for an NxN systolic MAC array of 8-bit floats.
// Accepts a job, clears the accumulators, drives the skewed operand
// wavefront for 3N-2 steps, then captures and presents the C matrix.
// All float arithmetic lives in the MAC cells; this block only routes operands.
module matmul_scheduler #(
   parameter int N = 3,
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [N*N*W-1:0] a_flat,
   input  logic [N*N*W-1:0] b_flat,
   output logic [N*N*W-1:0] mac_a,
   output logic [N*N*W-1:0] mac_b,
   output logic             acc_clr,
   output logic             acc_en,
   input  logic [N*N*W-1:0] c_flat,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [N*N*W-1:0] res_data,
   output logic             busy,
   output logic [3:0]       step
);

   localparam int         STEPS = 3 * N - 2;
   localparam logic [3:0] LAST  = 4'(STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_RUN     = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         s_q, s_d;
   logic [N*N*W-1:0]   a_q, a_d;
   logic [N*N*W-1:0]   b_q, b_d;
   logic [N*N*W-1:0]   res_q, res_d;
   logic               res_valid_q, res_valid_d;

   // Next-state logic: job acceptance, step counting and result capture.
   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      case (state_q)
         S_IDLE: begin
            s_d = 4'd0;
            if (start_valid) begin
               a_d     = a_flat;
               b_d     = b_flat;
               state_d = S_CLEAR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            s_d     = 4'd0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (s_q == LAST) begin
               s_d     = 4'd0;
               state_d = S_CAPTURE;
            end else begin
               s_d     = s_q + 4'd1;
            end
         end
         S_CAPTURE: begin
            res_d       = c_flat;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d     = S_DONE;
            end
         end
         default: begin
            s_d         = 4'd0;
            res_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // Operand wavefront: cell (i,j) consumes the k-th pair when s == i+j+k.
   always_comb begin
      mac_a = '0;
      mac_b = '0;
      if (state_q == S_RUN) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               for (int k = 0; k < N; k++) begin
                  if (int'(s_q) == i + j + k) begin
                     mac_a[(i*N+j)*W +: W] = a_q[(i*N+k)*W +: W];
                     mac_b[(i*N+j)*W +: W] = b_q[(k*N+j)*W +: W];
                  end else begin
                     mac_a[(i*N+j)*W +: W] = mac_a[(i*N+j)*W +: W];
                     mac_b[(i*N+j)*W +: W] = mac_b[(i*N+j)*W +: W];
                  end
               end
            end
         end
      end else begin
         mac_a = '0;
         mac_b = '0;
      end
   end

   // Status and array-control decodes of the current state.
   always_comb begin
      start_ready = (state_q == S_IDLE);
      busy        = (state_q != S_IDLE);
      acc_clr     = (state_q == S_CLEAR);
      acc_en      = (state_q == S_RUN);
      if (state_q == S_RUN) begin
         step = s_q;
      end else begin
         step = 4'd0;
      end
   end

   // State, step counter, latched operands and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         s_q         <= 4'd0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_q;

endmodule
